// File: rtl/rob_commit_pkg.sv
// Shared reorder-buffer types and sizing for the rename/commit slice.
package rob_commit_pkg;

  localparam int ROB_DEPTH     = 32;
  localparam int ROB_IDX_WIDTH = 5;

  typedef logic [ROB_IDX_WIDTH-1:0] rob_idx_t;
  // Pointer carries one extra MSB used as the wrap bit.
  typedef logic [ROB_IDX_WIDTH:0]   rob_ptr_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        regf_we;
    logic [4:0]  rd_addr;
    logic [31:0] data;
  } rob_entry_t;

  // Fields of the commit bus; the rename table's cdb is built from this.
  typedef struct packed {
    logic        valid;
    logic        regf_we;
    logic [4:0]  rd_addr;
    logic [31:0] data;
  } commit_bus_t;

endpackage

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates at tail, captures out-of-order results,
// retires one entry per cycle from head, and serves operand lookups.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic [4:0]               alloc_rd_addr,
  input  logic                     alloc_regf_we,
  output logic                     alloc_ready,
  output logic [ROB_IDX_WIDTH-1:0] alloc_rob_idx,
  input  logic                     wb_valid,
  input  logic [ROB_IDX_WIDTH-1:0] wb_rob_idx,
  input  logic [31:0]              wb_data,
  input  logic [ROB_IDX_WIDTH-1:0] rs1_rob_idx,
  input  logic [ROB_IDX_WIDTH-1:0] rs2_rob_idx,
  output logic                     rs1_done,
  output logic                     rs2_done,
  output logic [31:0]              rs1_data,
  output logic [31:0]              rs2_data,
  output logic                     commit_valid,
  output logic                     commit_regf_we,
  output logic [4:0]               commit_rd_addr,
  output logic [31:0]              commit_data,
  output logic [ROB_IDX_WIDTH-1:0] commit_rob_idx
);

  rob_entry_t  entry [ROB_DEPTH];
  rob_ptr_t    head;
  rob_ptr_t    tail;
  commit_bus_t commit_bus;
  rob_idx_t    commit_idx;

  rob_idx_t head_idx;
  rob_idx_t tail_idx;
  logic     full;
  logic     do_alloc;
  logic     do_commit;

  assign head_idx  = head[ROB_IDX_WIDTH-1:0];
  assign tail_idx  = tail[ROB_IDX_WIDTH-1:0];
  assign full      = (head_idx == tail_idx) && (head[ROB_IDX_WIDTH] != tail[ROB_IDX_WIDTH]);
  assign do_alloc  = alloc_valid && !full;
  // Retirement looks only at registered done, so a writeback edge never retires.
  assign do_commit = entry[head_idx].valid && entry[head_idx].done;

  assign alloc_ready   = !full;
  assign alloc_rob_idx = tail_idx;

  assign commit_valid   = commit_bus.valid;
  assign commit_regf_we = commit_bus.regf_we;
  assign commit_rd_addr = commit_bus.rd_addr;
  assign commit_data    = commit_bus.data;
  assign commit_rob_idx = commit_idx;

  // Entry storage, pointers and registered commit bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      commit_bus <= '0;
      commit_idx <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entry[i].valid <= 1'b0;
        entry[i].done  <= 1'b0;
      end
    end else begin
      // Results for freed slots are dropped; the slot being allocated is free.
      if (wb_valid && entry[wb_rob_idx].valid) begin
        entry[wb_rob_idx].done <= 1'b1;
        entry[wb_rob_idx].data <= wb_data;
      end
      if (do_alloc) begin
        entry[tail_idx].valid   <= 1'b1;
        entry[tail_idx].done    <= 1'b0;
        entry[tail_idx].regf_we <= alloc_regf_we;
        entry[tail_idx].rd_addr <= alloc_rd_addr;
        tail                    <= tail + 1'b1;
      end
      if (do_commit) begin
        entry[head_idx].valid <= 1'b0;
        entry[head_idx].done  <= 1'b0;
        commit_bus.valid      <= 1'b1;
        commit_bus.regf_we    <= entry[head_idx].regf_we && (entry[head_idx].rd_addr != 5'd0);
        commit_bus.rd_addr    <= entry[head_idx].rd_addr;
        commit_bus.data       <= entry[head_idx].data;
        commit_idx            <= head_idx;
        head                  <= head + 1'b1;
      end else begin
        commit_bus.valid <= 1'b0;
      end
    end
  end

  // Two identical operand lookup ports with same-cycle writeback bypass.
  for (genvar gi = 0; gi < 2; gi++) begin : g_look
    rob_idx_t    idx;
    logic        done_c;
    logic [31:0] data_c;

    assign idx = (gi == 0) ? rs1_rob_idx : rs2_rob_idx;

    // Bypass wins over stored data so a result is visible on its writeback cycle.
    always_comb begin
      done_c = 1'b0;
      data_c = 32'd0;
      if (entry[idx].valid) begin
        if (wb_valid && (wb_rob_idx == idx)) begin
          done_c = 1'b1;
          data_c = wb_data;
        end else if (entry[idx].done) begin
          done_c = 1'b1;
          data_c = entry[idx].data;
        end
      end
    end
  end

  assign rs1_done = g_look[0].done_c;
  assign rs1_data = g_look[0].data_c;
  assign rs2_done = g_look[1].done_c;
  assign rs2_data = g_look[1].data_c;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit with hand-computed expectations.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd_addr;
  logic        alloc_regf_we;
  logic        alloc_ready;
  logic [4:0]  alloc_rob_idx;
  logic        wb_valid;
  logic [4:0]  wb_rob_idx;
  logic [31:0] wb_data;
  logic [4:0]  rs1_rob_idx;
  logic [4:0]  rs2_rob_idx;
  logic        rs1_done;
  logic        rs2_done;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        commit_valid;
  logic        commit_regf_we;
  logic [4:0]  commit_rd_addr;
  logic [31:0] commit_data;
  logic [4:0]  commit_rob_idx;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_rd_addr  (alloc_rd_addr),
    .alloc_regf_we  (alloc_regf_we),
    .alloc_ready    (alloc_ready),
    .alloc_rob_idx  (alloc_rob_idx),
    .wb_valid       (wb_valid),
    .wb_rob_idx     (wb_rob_idx),
    .wb_data        (wb_data),
    .rs1_rob_idx    (rs1_rob_idx),
    .rs2_rob_idx    (rs2_rob_idx),
    .rs1_done       (rs1_done),
    .rs2_done       (rs2_done),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .commit_valid   (commit_valid),
    .commit_regf_we (commit_regf_we),
    .commit_rd_addr (commit_rd_addr),
    .commit_data    (commit_data),
    .commit_rob_idx (commit_rob_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("  ok %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_commit(input string tag, input logic [4:0] rd, input logic we,
                              input logic [31:0] data, input logic [4:0] idx);
    check({tag, ".valid"}, commit_valid, 1'b1);
    check({tag, ".we"},    commit_regf_we, we);
    check({tag, ".rd"},    commit_rd_addr, rd);
    check({tag, ".data"},  commit_data, data);
    check({tag, ".idx"},   commit_rob_idx, idx);
  endtask

  initial begin
    rst           = 1'b1;
    alloc_valid   = 1'b0;
    alloc_rd_addr = 5'd0;
    alloc_regf_we = 1'b0;
    wb_valid      = 1'b0;
    wb_rob_idx    = 5'd0;
    wb_data       = 32'd0;
    rs1_rob_idx   = 5'd0;
    rs2_rob_idx   = 5'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst.ready", alloc_ready, 1'b1);
    check("rst.idx", alloc_rob_idx, 5'd0);
    check("rst.cvalid", commit_valid, 1'b0);
    check("rst.cdata", commit_data, 32'd0);
    check("rst.crd", commit_rd_addr, 5'd0);

    // Three allocations, rd = 1, 2, 3
    for (int i = 0; i < 3; i++) begin
      alloc_valid   = 1'b1;
      alloc_rd_addr = 5'(i + 1);
      alloc_regf_we = 1'b1;
      #1;
      check("alloc3.idx", alloc_rob_idx, 32'(i));
      tick();
    end
    alloc_valid = 1'b0;

    // Out-of-order writeback: idx2, idx0, idx1
    wb_valid = 1'b1; wb_rob_idx = 5'd2; wb_data = 32'h33;
    tick();
    check("ooo.nocommit_a", commit_valid, 1'b0);
    wb_rob_idx = 5'd0; wb_data = 32'h11;
    tick();
    check("ooo.nocommit_wbedge", commit_valid, 1'b0);
    wb_rob_idx = 5'd1; wb_data = 32'h22;
    tick();
    wb_valid = 1'b0;
    check_commit("ooo.c0", 5'd1, 1'b1, 32'h11, 5'd0);
    tick();
    check_commit("ooo.c1", 5'd2, 1'b1, 32'h22, 5'd1);
    tick();
    check_commit("ooo.c2", 5'd3, 1'b1, 32'h33, 5'd2);
    tick();
    check("ooo.idle", commit_valid, 1'b0);
    check("ooo.hold", commit_data, 32'h33);

    // Fill all 32 entries from a clean start
    do_reset();
    for (int i = 0; i < 32; i++) begin
      alloc_valid   = 1'b1;
      alloc_rd_addr = 5'd5;
      alloc_regf_we = 1'b1;
      #1;
      if (i == 0 || i == 31) begin
        check("fill.ready", alloc_ready, 1'b1);
        check("fill.idx", alloc_rob_idx, 32'(i));
      end
      tick();
    end
    check("full.ready", alloc_ready, 1'b0);
    tick();  // 33rd request while full
    alloc_valid = 1'b0;
    check("full.ready_after33", alloc_ready, 1'b0);
    check("full.tail_after33", alloc_rob_idx, 5'd0);
    wb_valid = 1'b1; wb_rob_idx = 5'd0; wb_data = 32'h500;
    tick();
    wb_valid = 1'b0;
    check("full.nocommit_wbedge", commit_valid, 1'b0);
    tick();
    check_commit("full.c0", 5'd5, 1'b1, 32'h500, 5'd0);
    check("full.ready_freed", alloc_ready, 1'b1);
    check("full.wrap_idx", alloc_rob_idx, 5'd0);

    // rd = 0 never writes the register file; regf_we = 0 passes through
    do_reset();
    alloc_valid = 1'b1; alloc_rd_addr = 5'd0; alloc_regf_we = 1'b1;
    tick();
    alloc_rd_addr = 5'd7; alloc_regf_we = 1'b0;
    tick();
    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_rob_idx = 5'd0; wb_data = 32'hDEAD;
    tick();
    wb_rob_idx = 5'd1; wb_data = 32'h77;
    tick();
    wb_valid = 1'b0;
    check_commit("rd0.c0", 5'd0, 1'b0, 32'hDEAD, 5'd0);
    tick();
    check_commit("nowe.c1", 5'd7, 1'b0, 32'h77, 5'd1);
    tick();
    check("nowe.idle", commit_valid, 1'b0);

    // Operand lookup: allocate idx 2, 3, 4
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_rd_addr = 5'(8 + i); alloc_regf_we = 1'b1;
      tick();
    end
    alloc_valid = 1'b0;
    rs1_rob_idx = 5'd4; rs2_rob_idx = 5'd3;
    wb_valid = 1'b1; wb_rob_idx = 5'd4; wb_data = 32'h44;
    #1;
    check("look.bypass_done", rs1_done, 1'b1);
    check("look.bypass_data", rs1_data, 32'h44);
    check("look.pending_done", rs2_done, 1'b0);
    check("look.pending_data", rs2_data, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("look.stored_done", rs1_done, 1'b1);
    check("look.stored_data", rs1_data, 32'h44);
    rs1_rob_idx = 5'd10; rs2_rob_idx = 5'd11;
    wb_valid = 1'b1; wb_rob_idx = 5'd11; wb_data = 32'hAA;
    #1;
    check("look.unalloc_done", rs1_done, 1'b0);
    check("look.unalloc_data", rs1_data, 32'd0);
    check("look.unalloc_byp_done", rs2_done, 1'b0);
    check("look.unalloc_byp_data", rs2_data, 32'd0);
    tick();
    wb_valid = 1'b0;

    // Reset with 5 pending (idx 2..6), idx 3 and 4 done, head idx 2 not done
    alloc_valid = 1'b1; alloc_rd_addr = 5'd12; alloc_regf_we = 1'b1;
    wb_valid = 1'b1; wb_rob_idx = 5'd3; wb_data = 32'h333;
    tick();
    wb_valid = 1'b0;
    tick();
    alloc_valid = 1'b0;
    check("pend.nocommit", commit_valid, 1'b0);
    check("pend.tail", alloc_rob_idx, 5'd7);
    rst = 1'b1;
    tick();
    check("midrst.cvalid", commit_valid, 1'b0);
    check("midrst.cdata", commit_data, 32'd0);
    check("midrst.cidx", commit_rob_idx, 5'd0);
    rst = 1'b0;
    wb_valid = 1'b1; wb_rob_idx = 5'd2; wb_data = 32'h222;
    tick();
    wb_valid = 1'b0;
    tick();
    tick();
    check("midrst.no_commit_after", commit_valid, 1'b0);
    check("midrst.ready", alloc_ready, 1'b1);
    alloc_valid = 1'b1; alloc_rd_addr = 5'd1; alloc_regf_we = 1'b1;
    #1;
    check("midrst.next_idx", alloc_rob_idx, 5'd0);
    tick();
    alloc_valid = 1'b0;
    check("midrst.tail_adv", alloc_rob_idx, 5'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order reorder buffer and the producer side of the rename/commit interface.
- Allocates a ROB index per dispatched instruction; the rename table records that index against rd.
- Captures out-of-order results from the functional units.
- Retires entries strictly in program order, driving the commit write (regf_we / rd_addr / data) that updates the architectural register file and clears the rename table's busy bit.
- Also answers operand-lookup queries by ROB index for dispatch.

Parameters:
- ROB_DEPTH, 32, number of entries; power of two.
- ROB_IDX_WIDTH, 5, log2(ROB_DEPTH); width of every ROB index.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_valid  in  1  dispatch requests an entry this cycle
- alloc_rd_addr  in  5  destination register of the dispatching instruction
- alloc_regf_we  in  1  instruction writes rd
- alloc_ready  out  1  ROB can accept an allocation this cycle
- alloc_rob_idx  out  ROB_IDX_WIDTH  index assigned when alloc_valid && alloc_ready (current tail)
- wb_valid  in  1  functional-unit result valid
- wb_rob_idx  in  ROB_IDX_WIDTH  entry the result belongs to
- wb_data  in  32  result value
- rs1_rob_idx, rs2_rob_idx  in  ROB_IDX_WIDTH  operand lookup indices
- rs1_done, rs2_done  out  1  looked-up entry valid and result available
- rs1_data, rs2_data  out  32  looked-up result; 0 when not done
- commit_valid  out  1  an entry retired this cycle
- commit_regf_we  out  1  retired entry writes the register file
- commit_rd_addr  out  5  retired destination register
- commit_data  out  32  retired result
- commit_rob_idx  out  ROB_IDX_WIDTH  index of the retired entry

Behaviour:
- Storage per entry: valid, done, regf_we, rd_addr[4:0], data[31:0].
- Pointers: head and tail are ROB_IDX_WIDTH+1 bits, with the MSB as wrap bit.
  - empty = (head == tail).
  - full = low bits equal and wrap bits differ.
- Reset:
  - head = tail = 0; all valid/done = 0.
  - commit_valid = 0, commit_regf_we = 0, commit_rd_addr = 0, commit_data = 0, commit_rob_idx = 0.
  - alloc_ready = 1 and alloc_rob_idx = 0 in the cycle after reset.
  - Reset asserted mid-operation discards all entries; no commit is emitted in the reset cycle.
- Allocation:
  - alloc_ready = !full, from registered state only; no same-cycle bypass from commit.
  - alloc_rob_idx = tail[ROB_IDX_WIDTH-1:0], combinational.
  - On alloc_valid && alloc_ready at posedge: entry[tail] gets valid = 1, done = 0, rd_addr and regf_we captured; tail increments (wraps via the MSB).
  - alloc_valid while full is ignored; no state change.
- Writeback:
  - On wb_valid at posedge, if entry[wb_rob_idx].valid: done = 1, data = wb_data.
  - Writeback to an invalid entry is ignored.
  - Duplicate writeback overwrites data.
- Commit (registered outputs, one entry per cycle max):
  - At posedge, if entry[head] is valid && done, the commit outputs are loaded from that entry, commit_valid = 1, entry valid/done are cleared, and head increments.
  - Otherwise commit_valid = 0 and the other commit outputs hold their last values.
  - commit_regf_we = entry.regf_we && (rd_addr != 0).
  - Latency: a writeback to the head entry at edge N produces commit_valid high in the cycle after edge N+1.
  - An entry is never retired in the same edge as its writeback.
- Simultaneous events:
  - Alloc and commit on the same edge: both occur; when full, the freed slot is usable from the next cycle.
  - Writeback and alloc to the same index on the same edge cannot occur; that index is free, so the writeback is ignored per the invalid-entry rule.
- Operand lookup (combinational):
  - rsN_done = valid[idx] && (done[idx] || (wb_valid && wb_rob_idx == idx)).
  - rsN_data returns wb_data on a bypass hit, stored data if done, and 0 otherwise.
- Index wrap: index ROB_DEPTH-1 is followed by 0, with the wrap bit toggled.

Decomposition:
- rv32i_types gains:
  - rob_entry_t struct (valid, done, regf_we, rd_addr, data).
  - ROB_DEPTH and ROB_IDX_WIDTH localparams shared with the rename table and reservation stations.
- The commit-bus fields are exposed as a packed struct in the package; the rename table's cdb is built from it.
- No sub-module is needed. The pointer logic is small enough to stay inline.

Test Plan:
- Reset -> alloc_ready = 1, alloc_rob_idx = 0, commit_valid = 0.
  - alloc x3 (rd = 1, 2, 3) -> alloc_rob_idx returns 0, 1, 2.
- Out-of-order writeback: wb idx2 = 0x33, then idx0 = 0x11, then idx1 = 0x22.
  - Commits are rd 1 = 0x11, rd 2 = 0x22, rd 3 = 0x33, in that order.
  - Each commit lands one cycle after the head's writeback edge.
- Allocate 32 without writeback -> alloc_ready drops after the 32nd; a 33rd alloc_valid leaves tail unchanged.
  - wb idx0 -> commit, then alloc_ready = 1 and alloc_rob_idx = 0 (wrap).
- Entry with rd = 0, regf_we = 1, wb 0xDEAD -> commit_valid = 1, commit_regf_we = 0.
- Lookup rs1_rob_idx = 4 while wb_valid with idx 4 and 0x44 -> same cycle rs1_done = 1, rs1_data = 0x44.
  - A lookup of an unallocated idx -> rs1_done = 0, rs1_data = 0.
- Reset asserted with 5 entries pending (2 done) -> no commit afterwards.
  - Next alloc returns idx 0.
